// File: rtl/resonator_ddc_control_deadlock_reporter.sv
// Deadlock watchdog for the DDC control monitor: qualifies long stalls, latches
// the implicated stream channels and stall start time, and emits one report per event.
module resonator_ddc_control_deadlock_reporter #(
    parameter int THRESH = 1024,  // legal range 2 .. 2**CNT_W-1
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            block,
    input  logic [1:0]      axis_block_sigs,
    input  logic            clear,
    input  logic            report_ready,
    output logic            deadlock,
    output logic            report_valid,
    output logic [1:0]      report_mask,
    output logic [TS_W-1:0] report_ts,
    output logic [15:0]     stall_episodes
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STALL  = 2'd1,
        S_REPORT = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(THRESH - 1);
    localparam logic [15:0]      EPI_MAX  = 16'hFFFF;

    state_t            r_state;
    logic [CNT_W-1:0]  r_run;
    logic [TS_W-1:0]   r_ts;
    logic [TS_W-1:0]   r_start_ts;
    logic [1:0]        r_acc_mask;
    logic              r_deadlock;
    logic              r_report_valid;
    logic [1:0]        r_report_mask;
    logic [TS_W-1:0]   r_report_ts;
    logic [15:0]       r_stall_episodes;

    // Timestamp, stall-run tracking and report FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_run            <= '0;
            r_ts             <= '0;
            r_start_ts       <= '0;
            r_acc_mask       <= 2'b00;
            r_deadlock       <= 1'b0;
            r_report_valid   <= 1'b0;
            r_report_mask    <= 2'b00;
            r_report_ts      <= '0;
            r_stall_episodes <= 16'd0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (block) begin
                        r_state    <= S_STALL;
                        r_run      <= CNT_W'(1);
                        r_start_ts <= r_ts;
                        r_acc_mask <= axis_block_sigs;
                    end
                end
                S_STALL: begin
                    if (block) begin
                        r_acc_mask <= r_acc_mask | axis_block_sigs;
                        // run counts samples already taken, so THRESH-1 here means this is sample THRESH
                        if (r_run == RUN_LAST) begin
                            r_state        <= S_REPORT;
                            r_report_mask  <= r_acc_mask | axis_block_sigs;
                            r_report_ts    <= r_start_ts;
                            r_deadlock     <= 1'b1;
                            r_report_valid <= 1'b1;
                        end else begin
                            r_run <= r_run + CNT_W'(1);
                        end
                    end else begin
                        r_state    <= S_IDLE;
                        r_run      <= '0;
                        r_acc_mask <= 2'b00;
                        if (r_stall_episodes != EPI_MAX) begin
                            r_stall_episodes <= r_stall_episodes + 16'd1;
                        end
                    end
                end
                S_REPORT: begin
                    if (report_ready) begin
                        r_state        <= S_HOLD;
                        r_report_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    // A block seen alongside clear is dropped; the next stall starts on a later sample
                    if (clear) begin
                        r_state    <= S_IDLE;
                        r_deadlock <= 1'b0;
                        r_run      <= '0;
                        r_acc_mask <= 2'b00;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_run          <= '0;
                    r_acc_mask     <= 2'b00;
                    r_deadlock     <= 1'b0;
                    r_report_valid <= 1'b0;
                end
            endcase
        end
    end

    assign deadlock       = r_deadlock;
    assign report_valid   = r_report_valid;
    assign report_mask    = r_report_mask;
    assign report_ts      = r_report_ts;
    assign stall_episodes = r_stall_episodes;

endmodule

// File: tb/tb_resonator_ddc_control_deadlock_reporter.sv
// Directed bench with a report scoreboard: stimulus queues expected reports,
// a monitor compares them whenever report_valid is presented.
module tb_resonator_ddc_control_deadlock_reporter;

    localparam int TS_W = 32;

    typedef struct packed {
        logic [1:0]      mask;
        logic [TS_W-1:0] ts;
    } rpt_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            block = 1'b0;
    logic [1:0]      axis_block_sigs = 2'b00;
    logic            clear = 1'b0;
    logic            report_ready = 1'b1;
    logic            deadlock;
    logic            report_valid;
    logic [1:0]      report_mask;
    logic [TS_W-1:0] report_ts;
    logic [15:0]     stall_episodes;

    int          n_checks = 0;
    int          n_fail   = 0;
    rpt_t        exp_q[$];
    logic [31:0] tb_ts;

    resonator_ddc_control_deadlock_reporter #(
        .THRESH(4), .CNT_W(16), .TS_W(TS_W)
    ) dut (
        .clock(clock), .reset(reset), .block(block),
        .axis_block_sigs(axis_block_sigs), .clear(clear),
        .report_ready(report_ready), .deadlock(deadlock),
        .report_valid(report_valid), .report_mask(report_mask),
        .report_ts(report_ts), .stall_episodes(stall_episodes)
    );

    always #5 clock = ~clock;

    // Reference cycle timestamp
    always @(posedge clock) begin
        if (reset) tb_ts <= 32'd0;
        else       tb_ts <= tb_ts + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, advance through one rising edge to the next negedge
    task automatic step(input logic b, input logic [1:0] s, input logic clr);
        block = b;
        axis_block_sigs = s;
        clear = clr;
        @(negedge clock);
    endtask

    // Report monitor
    initial begin
        rpt_t e;
        forever begin
            @(negedge clock);
            #1;
            if (report_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("report_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("report_mask", {30'd0, report_mask}, {30'd0, e.mask});
                    chk("report_ts", report_ts, e.ts);
                    if (report_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] t0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_deadlock", {31'd0, deadlock}, 32'd0);
        chk("rst_valid", {31'd0, report_valid}, 32'd0);
        chk("rst_mask", {30'd0, report_mask}, 32'd0);
        chk("rst_ts", report_ts, 32'd0);
        chk("rst_episodes", {16'd0, stall_episodes}, 32'd0);

        // Qualifying stall starting at ts=10, mask 01
        report_ready = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 1'b0);
        exp_q.push_back('{mask: 2'b01, ts: 32'd10});
        for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b0);
        chk("t1_deadlock_early", {31'd0, deadlock}, 32'd0);
        step(1'b1, 2'b01, 1'b0);
        chk("t1_deadlock", {31'd0, deadlock}, 32'd1);
        chk("t1_valid", {31'd0, report_valid}, 32'd1);
        step(1'b0, 2'b00, 1'b0);
        chk("t1_valid_fall", {31'd0, report_valid}, 32'd0);
        chk("t1_deadlock_hold", {31'd0, deadlock}, 32'd1);
        step(1'b0, 2'b00, 1'b1);
        chk("t1_clear", {31'd0, deadlock}, 32'd0);

        // Three recovered stalls of 3 cycles
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b0);
            chk("t2_no_deadlock", {31'd0, deadlock}, 32'd0);
            step(1'b0, 2'b00, 1'b0);
        end
        chk("t2_episodes", {16'd0, stall_episodes}, 32'd3);
        chk("t2_no_valid", {31'd0, report_valid}, 32'd0);

        // Mask accumulates 01 then 10; consumer stalls 5 cycles; clear ignored in REPORT
        report_ready = 1'b0;
        t0 = tb_ts;
        exp_q.push_back('{mask: 2'b11, ts: t0});
        step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_valid_held", {31'd0, report_valid}, 32'd1);
            step(1'b1, 2'b00, (i == 2) ? 1'b1 : 1'b0);
        end
        chk("t3_deadlock_report", {31'd0, deadlock}, 32'd1);
        report_ready = 1'b1;
        step(1'b0, 2'b00, 1'b0);
        chk("t3_valid_fall", {31'd0, report_valid}, 32'd0);
        chk("t3_deadlock_hold", {31'd0, deadlock}, 32'd1);
        chk("t3_mask_hold", {30'd0, report_mask}, 32'd3);

        // Clear with block high in HOLD; new stall counts from the following sample
        step(1'b1, 2'b01, 1'b1);
        chk("t4_clear", {31'd0, deadlock}, 32'd0);
        t0 = tb_ts;
        exp_q.push_back('{mask: 2'b01, ts: t0});
        for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b0);
        chk("t4_not_yet", {31'd0, deadlock}, 32'd0);
        step(1'b1, 2'b01, 1'b0);
        chk("t4_deadlock", {31'd0, deadlock}, 32'd1);
        chk("t4_valid", {31'd0, report_valid}, 32'd1);

        // Reset while the report is presented
        reset = 1'b1;
        step(1'b0, 2'b00, 1'b0);
        reset = 1'b0;
        chk("t5_deadlock", {31'd0, deadlock}, 32'd0);
        chk("t5_valid", {31'd0, report_valid}, 32'd0);
        chk("t5_mask", {30'd0, report_mask}, 32'd0);
        chk("t5_ts", report_ts, 32'd0);
        chk("t5_episodes", {16'd0, stall_episodes}, 32'd0);

        // Saturation of the recovered-stall counter
        dut.r_stall_episodes = 16'hFFFD;
        step(1'b1, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        chk("t6_episodes_fffe", {16'd0, stall_episodes}, 32'h0000FFFE);
        step(1'b1, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        chk("t6_episodes_ffff", {16'd0, stall_episodes}, 32'h0000FFFF);
        step(1'b1, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        chk("t6_episodes_sat", {16'd0, stall_episodes}, 32'h0000FFFF);

        step(1'b0, 2'b00, 1'b0);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/resonator_ddc_control_deadlock_reporter.md
# resonator_ddc_control_deadlock_reporter

Watchdog and reporting stage that consumes the registered `block` flag and per-channel AXI-Stream block bits produced by the DDC control deadlock monitor. It qualifies a stall as a deadlock only after `THRESH` consecutive blocked cycles, latches which stream channels were implicated and when the stall began, and hands a single report per event to the control/status plane over a valid/ready handshake. Short stalls that recover are counted, not reported.

## Interface
- `THRESH`, 1024, consecutive blocked cycles that qualify a deadlock; legal range 2 .. 2^CNT_W-1
- `CNT_W`, 16, width of the stall-run counter
- `TS_W`, 32, width of the free-running cycle timestamp

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed
- `block`  in  1  registered stall flag from the monitor
- `axis_block_sigs`  in  2  per-channel AXIS block bits, same cycle alignment as `block`
- `clear`  in  1  single-cycle pulse; releases a held deadlock
- `report_ready`  in  1  consumer accepts report
- `deadlock`  out  1  sticky deadlock indication
- `report_valid`  out  1  report available
- `report_mask`  out  2  OR of `axis_block_sigs` over the qualifying stall
- `report_ts`  out  TS_W  timestamp of first blocked cycle of the qualifying stall
- `stall_episodes`  out  16  saturating count of recovered (non-deadlock) stalls

## Operation
- Free-running `ts` counter: increments every cycle; wraps modulo 2^TS_W; 0 after reset.
- FSM states: IDLE, STALL, REPORT, HOLD.
- IDLE: on `block`=1 -> STALL; `run`<=1, `start_ts`<=`ts`, `acc_mask`<=`axis_block_sigs`.
- STALL, `block`=1: `acc_mask`|=`axis_block_sigs`; if `run`==THRESH-1 -> REPORT (latch `report_mask`<=`acc_mask`|`axis_block_sigs`, `report_ts`<=`start_ts`, `deadlock`<=1), else `run`++.
- STALL, `block`=0: -> IDLE; `stall_episodes`++ (saturates at 0xFFFF, never wraps); `run`, `acc_mask` cleared.
- REPORT: `report_valid`=1; report fields stable; on `report_valid`&&`report_ready` -> HOLD. `block` and `clear` ignored in REPORT.
- HOLD: `deadlock` remains 1, `report_*` fields hold last values, `report_valid`=0. On `clear`=1 -> IDLE, `deadlock`<=0, `run`/`acc_mask` cleared. If `block`=1 in the same cycle as `clear`, transition still goes to IDLE; new stall starts on the next sampled `block`.
- `clear` in IDLE or STALL: no effect.
- Only one report per deadlock event; no new event detected until HOLD exits.
- `stall_episodes` never cleared by `clear`; only by `reset`.

## Timing
- All outputs registered. Reset values: `deadlock`=0, `report_valid`=0, `report_mask`=0, `report_ts`=0, `stall_episodes`=0; FSM=IDLE, `ts`=0, `run`=0.
- `block` first sampled high at edge k: `deadlock` and `report_valid` rise after edge k+THRESH-1 (visible cycle k+THRESH-1..k+THRESH), i.e. exactly THRESH samples of `block`=1.
- `block` low at any sample before THRESH: no report; `stall_episodes` updates one cycle later.
- `report_valid` falls the cycle after handshake; `report_ready` may be held high permanently (zero-wait accept, REPORT occupies 1 cycle).
- `deadlock` falls the cycle after `clear` sampled in HOLD.
- `reset` mid-operation (any state, including REPORT with `report_valid`=1): all state returns to reset values on that edge; pending report dropped.

## Test plan
- Reset, `block`=1 with `axis_block_sigs`=01 for THRESH=4 cycles starting at `ts`=10 -> `deadlock`=1, `report_valid`=1, `report_mask`=01, `report_ts`=10.
- `block` high 3 cycles then low (THRESH=4), repeated 3 times -> `deadlock` never asserts, `stall_episodes`=3.
- Qualifying stall with mask 01 then 10 mid-stall, `report_ready` low for 5 cycles -> `report_valid` held 5 cycles, fields stable, `report_mask`=11; accepted on ready, `report_valid`=0 next cycle, `deadlock` stays 1.
- In HOLD pulse `clear` with `block`=1 -> `deadlock`=0 next cycle, FSM IDLE; new stall counted from following `block` sample; `clear` during REPORT ignored.
- Assert `reset` while `report_valid`=1 -> all outputs 0 next cycle; force `stall_episodes` to 0xFFFF via recovered stalls -> remains 0xFFFF after another recovery.
